// File: rtl/counter.sv
// Modulo-N up/down counter with terminal-count flag and registered wrap pulse.
// Define COUNTER_OVF_CNT_EN to add a saturating 8-bit wrap counter on ovf_count.
module counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MOD_VALUE   = 16,
  parameter int unsigned RESET_VALUE = 0,
  parameter int unsigned COUNT_DOWN  = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
`ifdef COUNTER_OVF_CNT_EN
  ,
  output logic [7:0]       ovf_count
`endif
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_err_width
    $error("counter: WIDTH must be in 2..16");
  end
  if (MOD_VALUE < 2 || MOD_VALUE > (32'd1 << WIDTH)) begin : g_err_mod
    $error("counter: MOD_VALUE must be in 2..2**WIDTH");
  end
  if (RESET_VALUE >= MOD_VALUE) begin : g_err_rst
    $error("counter: RESET_VALUE must be less than MOD_VALUE");
  end

  localparam bit             FullMod  = (MOD_VALUE == (32'd1 << WIDTH));
  localparam bit             Down     = (COUNT_DOWN != 0);
  localparam logic [WIDTH-1:0] TopVal = WIDTH'(MOD_VALUE - 1);
  localparam logic [WIDTH-1:0] LastVal  = Down ? '0 : TopVal;
  localparam logic [WIDTH-1:0] FirstVal = Down ? TopVal : '0;
  localparam logic [WIDTH-1:0] RstVal   = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_last;

  assign at_last = (count_q == LastVal);

  always_comb begin
    count_d = count_q;
    if (FullMod) begin
      // Power-of-two modulus rolls over naturally in binary.
      count_d = Down ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
    end else if (at_last) begin
      count_d = FirstVal;
    end else begin
      count_d = Down ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
    end
    wrap_d = at_last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RstVal;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign tc    = at_last;
  assign wrap  = wrap_q;

`ifdef COUNTER_OVF_CNT_EN
  logic [7:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (at_last && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 8'd0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_count = ovf_q;
`endif

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: default, modulo-10 and count-down/reset-5 instances on a shared
// clock and reset.
module tb_counter;

  logic       clk;
  logic       rst_n;
  logic [3:0] cnt_up, cnt_m10, cnt_dn;
  logic       tc_up, tc_m10, tc_dn;
  logic       wr_up, wr_m10, wr_dn;
`ifdef COUNTER_OVF_CNT_EN
  logic [7:0] ovf_up, ovf_m10, ovf_dn;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference state for the three instances.
  int unsigned m_up, m_m10, m_dn;
  bit          w_up, w_m10, w_dn;

  counter u_up (
    .clk   (clk),
    .reset (rst_n),
    .count (cnt_up),
    .tc    (tc_up),
    .wrap  (wr_up)
`ifdef COUNTER_OVF_CNT_EN
    ,
    .ovf_count (ovf_up)
`endif
  );

  counter #(
    .MOD_VALUE (10)
  ) u_m10 (
    .clk   (clk),
    .reset (rst_n),
    .count (cnt_m10),
    .tc    (tc_m10),
    .wrap  (wr_m10)
`ifdef COUNTER_OVF_CNT_EN
    ,
    .ovf_count (ovf_m10)
`endif
  );

  counter #(
    .COUNT_DOWN  (1),
    .RESET_VALUE (5)
  ) u_dn (
    .clk   (clk),
    .reset (rst_n),
    .count (cnt_dn),
    .tc    (tc_dn),
    .wrap  (wr_dn)
`ifdef COUNTER_OVF_CNT_EN
    ,
    .ovf_count (ovf_dn)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_up = 0;  m_m10 = 0;  m_dn = 5;
    w_up = 0;  w_m10 = 0;  w_dn = 0;
  endtask

  task automatic tick();
    w_up  = (m_up == 15);
    m_up  = w_up ? 0 : m_up + 1;
    w_m10 = (m_m10 == 9);
    m_m10 = w_m10 ? 0 : m_m10 + 1;
    w_dn  = (m_dn == 0);
    m_dn  = w_dn ? 15 : m_dn - 1;
  endtask

  task automatic check_all();
    check("up.count",  32'(cnt_up),  m_up);
    check("up.tc",     32'(tc_up),   32'(m_up == 15));
    check("up.wrap",   32'(wr_up),   32'(w_up));
    check("m10.count", 32'(cnt_m10), m_m10);
    check("m10.tc",    32'(tc_m10),  32'(m_m10 == 9));
    check("m10.wrap",  32'(wr_m10),  32'(w_m10));
    check("dn.count",  32'(cnt_dn),  m_dn);
    check("dn.tc",     32'(tc_dn),   32'(m_dn == 0));
    check("dn.wrap",   32'(wr_dn),   32'(w_dn));
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    tick();
    check_all();
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    reset_model();
    check_all();
    check("rst.up", 32'(cnt_up), 0);
    check("rst.dn", 32'(cnt_dn), 5);
    check("rst.dn.tc", 32'(tc_dn), 0);

    // Release between edges; first edge after release advances by one.
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
    end
    check("edge15.count", 32'(cnt_up), 15);
    check("edge15.tc", 32'(tc_up), 1);
    step();
    check("wrap.count", 32'(cnt_up), 0);
    check("wrap.pulse", 32'(wr_up), 1);
    step();
    check("wrap.gone", 32'(wr_up), 0);

    for (int i = 0; i < 16 && m_up != 7; i++) begin
      step();
    end
    check("pre_rst.count", 32'(cnt_up), 7);

    // Asynchronous reset mid-cycle, then hold low across an edge.
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    check_all();
    check("async_rst.count", 32'(cnt_up), 0);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
    end
    check("restart.count", 32'(cnt_up), 3);

    // Reset while the wrap pulse is high must clear it without a clock.
    for (int i = 0; i < 20 && !w_up; i++) begin
      step();
    end
    check("pre_rst.wrap", 32'(wr_up), 1);
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    check_all();
    @(negedge clk) rst_n = 1'b1;
    step();

`ifdef COUNTER_OVF_CNT_EN
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("ovf.rst", 32'(ovf_up), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (16 * 100) @(posedge clk);
    #1;
    check("ovf.100", 32'(ovf_up), 100);
    repeat (16 * 200) @(posedge clk);
    #1;
    check("ovf.sat", 32'(ovf_up), 255);
    #2 rst_n = 1'b0;
    #1;
    check("ovf.clr", 32'(ovf_up), 0);
    @(negedge clk) rst_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
